// File: rtl/image_pkg.sv
// Shared types, image defaults and UART timing helper for the image loader slice.
package image_pkg;

    localparam int IMG_W          = 128;
    localparam int IMG_H          = 128;
    localparam int IMG_NUM_PIXELS = IMG_W * IMG_H;
    localparam int IMG_ADDR_W     = 14;

    // RX state encoding kept as plain constants so older blocks can compare against it.
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE      = 3'd0;
    localparam rx_state_t RX_START     = 3'd1;
    localparam rx_state_t RX_DATA      = 3'd2;
    localparam rx_state_t RX_PARITY    = 3'd3;
    localparam rx_state_t RX_STOP      = 3'd4;
    localparam rx_state_t RX_WAIT_HIGH = 3'd5;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_image_loader_if.sv
// Input-memory write bus driven by the UART image loader.
interface uart_image_loader_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] addressin;
    logic [7:0]        input_pixel;
    logic              pixel_we;
    logic              transfer_done;

    modport master (output addressin, output input_pixel, output pixel_we, output transfer_done);
    modport slave  (input  addressin, input  input_pixel, input  pixel_we, input  transfer_done);
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, 1-cycle rx_valid / rx_err strobes.
// Even parity bit checked only when UART_PARITY_EN is defined (8E1), otherwise 8N1.
module uart_rx_core
    import image_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // [1:0] is the synchroniser proper; [2] only delays for falling-edge detection.
    logic [2:0]       sync_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             par_err_reg, par_err_next;
    logic             rx_s, fall;

    assign rx_s = sync_reg[1];
    assign fall = sync_reg[2] & ~sync_reg[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg    <= 3'b111;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            par_err_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[1:0], rx};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        rx_valid     = 1'b0;
        rx_err       = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next     = '0;
                par_err_next = 1'b0;
                if (fall) state_next = RX_START;
            end
            RX_START: begin
                if (cnt_reg == HALF) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == FULL) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cnt_reg == FULL) begin
                    cnt_next     = '0;
                    par_err_next = rx_s ^ (^shift_reg);
                    state_next   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_reg == FULL) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        rx_valid   = ~par_err_reg;
                        rx_err     = par_err_reg;
                        state_next = RX_IDLE;
                    end else begin
                        rx_err     = 1'b1;
                        state_next = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) state_next = RX_IDLE;
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_reg;
    assign busy    = (state_reg != RX_IDLE);

endmodule

// File: rtl/uart_image_loader.sv
// Loads a NUM_PIXELS grayscale image from UART into input memory, then raises transfer_done.
// Define UART_PARITY_EN to expect an even-parity bit in every frame.
module uart_image_loader
    import image_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int NUM_PIXELS = IMG_NUM_PIXELS,
    parameter int ADDR_W     = IMG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx,
    input  logic                   restart,
    uart_image_loader_if.master    mem,
    output logic                   frame_error,
    output logic                   busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);

    logic [7:0]        rx_byte;
    logic              rx_valid, rx_err;
    logic [ADDR_W-1:0] cnt_reg, addr_reg;
    logic [7:0]        pixel_reg;
    logic              we_reg, done_reg, ferr_reg;
    logic              last_pending;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    // The final strobe is still on the bus while done is being raised; block writes then too.
    assign last_pending = we_reg && (addr_reg == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= '0;
            addr_reg  <= '0;
            pixel_reg <= '0;
            we_reg    <= 1'b0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (restart) begin
                cnt_reg  <= '0;
                addr_reg <= '0;
                done_reg <= 1'b0;
                ferr_reg <= 1'b0;
            end else begin
                if (rx_err) ferr_reg <= 1'b1;
                if (last_pending) done_reg <= 1'b1;
                if (rx_valid && !done_reg && !last_pending) begin
                    we_reg    <= 1'b1;
                    addr_reg  <= cnt_reg;
                    pixel_reg <= rx_byte;
                    if (cnt_reg != LAST) cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign mem.addressin     = addr_reg;
    assign mem.input_pixel   = pixel_reg;
    assign mem.pixel_we      = we_reg;
    assign mem.transfer_done = done_reg;
    assign frame_error       = ferr_reg;

endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench for uart_image_loader with a write scoreboard (10 clocks per bit, 4-pixel image).
// Parity step runs only when UART_PARITY_EN is defined.
module tb_uart_image_loader;

    localparam int CPB  = 10;
    localparam int NPIX = 4;
    localparam int AW   = 2;
    localparam int GAP  = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic restart = 1'b0;
    logic frame_error, busy;

    int checks = 0;
    int errors = 0;
    logic [AW+7:0] sb_q[$];
    logic done_due = 1'b0;

    uart_image_loader_if #(.ADDR_W(AW)) mem_if ();

    uart_image_loader #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .NUM_PIXELS (NPIX),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .restart     (restart),
        .mem         (mem_if),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (done_due) begin
            chk("done_after_last", {31'd0, mem_if.transfer_done}, 32'd1);
            done_due = 1'b0;
        end
        if (mem_if.pixel_we === 1'b1) begin
            $display("write addr=%0d data=%02h", mem_if.addressin, mem_if.input_pixel);
            if (sb_q.size() > 0) begin
                logic [AW+7:0] exp_w;
                exp_w = sb_q.pop_front();
                chk("write_addr_data", {22'd0, mem_if.addressin, mem_if.input_pixel}, {22'd0, exp_w});
            end else begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: observed addr=%0d data=%02h required no write",
                       mem_if.addressin, mem_if.input_pixel);
            end
            chk("done_low_at_write", {31'd0, mem_if.transfer_done}, 32'd0);
            if (mem_if.addressin == AW'(NPIX - 1)) done_due = 1'b1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic bad_par);
        uart_rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(CPB);
        end
`ifdef UART_PARITY_EN
        uart_rx = (^b) ^ bad_par;
        wait_cycles(CPB);
`else
        if (bad_par) $display("note: parity request ignored in 8N1 build");
`endif
        uart_rx = stop_b;
        wait_cycles(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input logic expect_write, input logic [AW-1:0] addr);
        if (expect_write) sb_q.push_back({addr, b});
        send_frame(b, 1'b1, 1'b0);
        wait_cycles(GAP);
        $display("sent byte %02h", b);
        chk("sb_drained", sb_q.size(), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        wait_cycles(1);
        restart = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_cycles(3);
        chk("reset_we",    {31'd0, mem_if.pixel_we},      32'd0);
        chk("reset_addr",  {30'd0, mem_if.addressin},     32'd0);
        chk("reset_done",  {31'd0, mem_if.transfer_done}, 32'd0);
        chk("reset_busy",  {31'd0, busy},                 32'd0);
        rst = 1'b1;
        wait_cycles(5);

        // 1: fill the image
        send_good(8'h11, 1'b1, 2'd0);
        send_good(8'h22, 1'b1, 2'd1);
        send_good(8'h33, 1'b1, 2'd2);
        send_good(8'h44, 1'b1, 2'd3);
        chk("done_after_fill", {31'd0, mem_if.transfer_done}, 32'd1);
        chk("ferr_after_fill", {31'd0, frame_error},          32'd0);

        // 2: bytes after done are dropped; restart re-arms
        send_good(8'h55, 1'b0, 2'd0);
        chk("addr_held",  {30'd0, mem_if.addressin},   32'd3);
        chk("pixel_held", {24'd0, mem_if.input_pixel}, 32'h44);
        chk("done_held",  {31'd0, mem_if.transfer_done}, 32'd1);
        pulse_restart();
        chk("restart_done", {31'd0, mem_if.transfer_done}, 32'd0);
        chk("restart_addr", {30'd0, mem_if.addressin},     32'd0);
        send_good(8'hA5, 1'b1, 2'd0);
        chk("done_after_a5", {31'd0, mem_if.transfer_done}, 32'd0);

        // 3: framing error, line held low, then recovery
        pulse_restart();
        send_frame(8'h3C, 1'b0, 1'b0);
        uart_rx = 1'b0;
        wait_cycles(30);
        uart_rx = 1'b1;
        wait_cycles(GAP);
        $display("sent byte 3c with bad stop bit");
        chk("ferr_set", {31'd0, frame_error}, 32'd1);
        chk("sb_after_ferr", sb_q.size(), 32'd0);
        send_good(8'h7E, 1'b1, 2'd0);
        chk("ferr_sticky", {31'd0, frame_error}, 32'd1);

        // 4: short low glitch is rejected
        pulse_restart();
        chk("ferr_cleared", {31'd0, frame_error}, 32'd0);
        uart_rx = 1'b0;
        wait_cycles(3);
        uart_rx = 1'b1;
        wait_cycles(1);
        $display("glitch of 3 cycles");
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        wait_cycles(20);
        chk("glitch_idle", {31'd0, busy},        32'd0);
        chk("glitch_ferr", {31'd0, frame_error}, 32'd0);

        // 5: asynchronous reset mid-frame
        pulse_restart();
        send_good(8'hC3, 1'b1, 2'd0);
        send_good(8'h5A, 1'b1, 2'd1);
        uart_rx = 1'b0;
        wait_cycles(CPB);
        uart_rx = 1'b1;
        wait_cycles(CPB + 5);
        chk("midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        $display("reset asserted mid-frame");
        chk("arst_addr",  {30'd0, mem_if.addressin},     32'd0);
        chk("arst_pixel", {24'd0, mem_if.input_pixel},   32'd0);
        chk("arst_we",    {31'd0, mem_if.pixel_we},      32'd0);
        chk("arst_done",  {31'd0, mem_if.transfer_done}, 32'd0);
        chk("arst_ferr",  {31'd0, frame_error},          32'd0);
        chk("arst_busy",  {31'd0, busy},                 32'd0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(GAP);
        send_good(8'h99, 1'b1, 2'd0);

`ifdef UART_PARITY_EN
        // 6: even parity check
        pulse_restart();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(GAP);
        $display("sent byte 07 with wrong parity");
        chk("par_ferr", {31'd0, frame_error}, 32'd1);
        chk("par_sb",   sb_q.size(),          32'd0);
        send_good(8'h07, 1'b1, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
